id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
Decode stage directly downstream of the fetch stage. It latches the 65-bit fetch bundle, reads the external register file, and resolves operands through EX/MEM/WB bypasses or a stall. It resolves LA32R branches and jumps and returns the redirect `br_zip` to fetch. It forwards a 129-bit bundle to the execute stage over a valid/allowin handshake.

Parameters:
FWD_EN, 1, 1 = bypass from EX/MEM/WB; 0 = any RAW match on a valid producer stalls instead

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
fs2ds_valid  in  1  fetch bundle valid
fs2ds_bus  in  65  {adef, pc[31:0], inst[31:0]}
ds_allowin  out  1  decode can accept this cycle
br_zip  out  33  {br_taken, br_target[31:0]}
ds2es_valid  out  1  bundle to EX valid
ds2es_bus  out  129  {adef, pc, inst, rj_val, rkd_val}
es_allowin  in  1  EX can accept
rf_raddr1  out  5  regfile read address 1 (rj)
rf_raddr2  out  5  regfile read address 2 (rk or rd)
rf_rdata1  in  32  combinational read data 1
rf_rdata2  in  32  combinational read data 2
es_fwd  in  39  {blk, we, dest[4:0], val[31:0]} from EX; blk=1: result not yet available (load/CSR)
ms_fwd  in  39  same format from MEM
ws_fwd  in  38  {we, dest[4:0], val[31:0]} from WB
ws_ex  in  1  exception flush
ertn_flush  in  1  ertn flush

Behaviour:
- Reset (async, resetn=0): ds_valid=0; latched pc, inst and adef = 0. Outputs ds2es_valid=0, br_zip=0, ds2es_bus pc/inst fields=0.
- flush = ws_ex | ertn_flush.
- ds_allowin = ~ds_valid | (ds_ready_go & es_allowin).
- ds2es_valid = ds_valid & ds_ready_go & ~flush.
- Register update at posedge:
  - if flush: ds_valid <= 0.
  - else if ds_allowin: ds_valid <= fs2ds_valid & ~br_taken, and the bundle is latched when fs2ds_valid. This discards the sequential instruction fetched alongside a taken branch.
- Register addresses: rf_raddr1 = inst[9:5]. rf_raddr2 = inst[4:0] for branches (opcode[31:26] 0x16–0x1B) and stores (inst[31:22] 0x0A4/0x0A5/0x0A6); otherwise inst[14:10].
- Source usage:
  - src1 is used unless the opcode is b (0x14), bl (0x15), lu12i.w or pcaddu12i (inst[31:25] 0x0A/0x0E).
  - src2 is always treated as used (conservative).
  - Address 0 never matches and reads as 0.
- Operand resolution (FWD_EN=1): priority EX > MEM > WB > regfile. A stage matches when its valid & we & dest==addr & addr!=0.
- Stall: ds_ready_go = 0 if a used source matches EX with blk=1, or MEM with blk=1. With FWD_EN=0, any EX/MEM/WB match stalls. Otherwise ds_ready_go=1.
- Branch resolution (only when ds_valid & ~adef):
  - beq/bne/blt/bge/bltu/bgeu compare rj_val against rd value (signed for blt/bge, unsigned for bltu/bgeu). Target = pc + sext({inst[25:10],2'b00}).
  - b/bl: always taken. Target = pc + sext({inst[9:0],inst[25:10],2'b00}).
  - jirl: always taken. Target = rj_val + sext({inst[25:10],2'b00}).
  - br_taken = ds_valid & ds_ready_go & es_allowin & ~flush & cond. br_target is meaningful only while br_taken=1, otherwise 0.
  - br_taken is a single-cycle pulse per branch instruction. It is never asserted while stalled.
- The adef bit passes through unchanged; an adef instruction (NOP 0x03400000) never branches.
- Flush during a stall drops the held instruction. Nothing is emitted that cycle.
- All 32-bit additions wrap modulo 2^32.

Test Plan:
1. Reset, then fs2ds bundle pc=0x1C000000 inst=0x02800421 (addi.w r1,r1,1) with es_allowin=1 → next cycle ds2es_valid=1, bus pc=0x1C000000, rj_val=rf_rdata1, br_zip=0.
2. beq r1,r2,+8 (inst=0x58000822) at pc=0x1C000010 with r1=r2=5 → br_zip={1,0x1C000018} for one cycle; the bundle with pc 0x1C000014 arriving that edge is discarded (ds_valid=0 next cycle).
3. es_fwd={blk=1,we=1,dest=3}, decode add.w r4,r3,r5 → ds_allowin=0, ds2es_valid=0. When blk drops and ms_fwd carries r3=0x1234, issue with rj_val=0x1234.
4. es, ms and ws all write r6 with values 0xA, 0xB, 0xC; decode reads r6 → rj_val=0xA. Remove es → 0xB. Remove ms → 0xC.
5. Stalled on load-use, then ws_ex=1 → ds2es_valid=0 that cycle; ds_valid=0 next cycle; br_zip stays 0.
6. jirl r0,r1,0 with r1=0x1C000100; FWD_EN=0 with ws_fwd writing r1 → stall until ws clears, then br_zip={1,0x1C000100}. Separately, an adef bundle → no branch, adef=1 on ds2es_bus.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage: latches the fetch bundle, resolves operands via EX/MEM/WB bypass or stall,
// resolves LA32R branches/jumps and hands a bundle to execute over valid/allowin.
module id_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         fs2ds_valid,
  input  logic [64:0]  fs2ds_bus,
  output logic         ds_allowin,
  output logic [32:0]  br_zip,
  output logic         ds2es_valid,
  output logic [128:0] ds2es_bus,
  input  logic         es_allowin,
  output logic [4:0]   rf_raddr1,
  output logic [4:0]   rf_raddr2,
  input  logic [31:0]  rf_rdata1,
  input  logic [31:0]  rf_rdata2,
  input  logic [38:0]  es_fwd,
  input  logic [38:0]  ms_fwd,
  input  logic [37:0]  ws_fwd,
  input  logic         ws_ex,
  input  logic         ertn_flush
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  typedef struct packed {
    logic            blk;
    logic            we;
    logic [RW-1:0]   dest;
    logic [XLEN-1:0] val;
  } fwd_t;

  logic            ds_valid;
  logic            ds_adef;
  logic [XLEN-1:0] ds_pc;
  logic [XLEN-1:0] ds_inst;

  fwd_t es_f, ms_f, ws_f;
  logic [5:0]      op6;
  logic            is_bcc, is_st, src1_used;
  logic            es_hit1, ms_hit1, ws_hit1, es_hit2, ms_hit2, ws_hit2;
  logic            blk1, blk2, ds_ready_go, flush;
  logic [XLEN-1:0] rj_val, rkd_val;
  logic [XLEN-1:0] off16, off26;
  logic            br_cond, br_taken;
  logic [XLEN-1:0] br_target;

  function automatic logic hit(input fwd_t f, input logic [RW-1:0] a);
    return f.we && (f.dest == a) && (a != RW'(0));
  endfunction

  assign es_f = es_fwd;
  assign ms_f = ms_fwd;
  assign ws_f = {1'b0, ws_fwd};

  assign flush = ws_ex | ertn_flush;

  // Decode of register sources
  assign op6       = ds_inst[31:26];
  assign is_bcc    = (op6 >= 6'h16) && (op6 <= 6'h1B);
  assign is_st     = (ds_inst[31:22] == 10'h0A4) || (ds_inst[31:22] == 10'h0A5) ||
                     (ds_inst[31:22] == 10'h0A6);
  assign src1_used = !((op6 == 6'h14) || (op6 == 6'h15) ||
                       (ds_inst[31:25] == 7'h0A) || (ds_inst[31:25] == 7'h0E));
  assign rf_raddr1 = ds_inst[9:5];
  assign rf_raddr2 = (is_bcc || is_st) ? ds_inst[4:0] : ds_inst[14:10];

  assign es_hit1 = hit(es_f, rf_raddr1);
  assign ms_hit1 = hit(ms_f, rf_raddr1);
  assign ws_hit1 = hit(ws_f, rf_raddr1);
  assign es_hit2 = hit(es_f, rf_raddr2);
  assign ms_hit2 = hit(ms_f, rf_raddr2);
  assign ws_hit2 = hit(ws_f, rf_raddr2);

  // Operand select: youngest producer wins; r0 is hard zero
  always_comb begin
    rj_val  = '0;
    rkd_val = '0;
    if (rf_raddr1 != RW'(0)) begin
      if (FWD_EN && es_hit1)      rj_val = es_f.val;
      else if (FWD_EN && ms_hit1) rj_val = ms_f.val;
      else if (FWD_EN && ws_hit1) rj_val = ws_f.val;
      else                        rj_val = rf_rdata1;
    end
    if (rf_raddr2 != RW'(0)) begin
      if (FWD_EN && es_hit2)      rkd_val = es_f.val;
      else if (FWD_EN && ms_hit2) rkd_val = ms_f.val;
      else if (FWD_EN && ws_hit2) rkd_val = ws_f.val;
      else                        rkd_val = rf_rdata2;
    end
  end

  always_comb begin
    if (FWD_EN) begin
      blk1 = (es_hit1 & es_f.blk) | (ms_hit1 & ms_f.blk);
      blk2 = (es_hit2 & es_f.blk) | (ms_hit2 & ms_f.blk);
    end else begin
      blk1 = es_hit1 | ms_hit1 | ws_hit1;
      blk2 = es_hit2 | ms_hit2 | ws_hit2;
    end
  end

  // src2 is treated as always used, so any hazard on it stalls
  assign ds_ready_go = !((src1_used & blk1) | blk2);
  assign ds_allowin  = ~ds_valid | (ds_ready_go & es_allowin);
  assign ds2es_valid = ds_valid & ds_ready_go & ~flush;
  assign ds2es_bus   = {ds_adef, ds_pc, ds_inst, rj_val, rkd_val};

  assign off16 = {{14{ds_inst[25]}}, ds_inst[25:10], 2'b00};
  assign off26 = {{4{ds_inst[9]}}, ds_inst[9:0], ds_inst[25:10], 2'b00};

  always_comb begin
    br_cond   = 1'b0;
    br_target = ds_pc + off16;
    case (op6)
      6'h13:        begin br_cond = 1'b1; br_target = rj_val + off16; end
      6'h14, 6'h15: begin br_cond = 1'b1; br_target = ds_pc + off26; end
      6'h16:        br_cond = (rj_val == rkd_val);
      6'h17:        br_cond = (rj_val != rkd_val);
      6'h18:        br_cond = ($signed(rj_val) <  $signed(rkd_val));
      6'h19:        br_cond = ($signed(rj_val) >= $signed(rkd_val));
      6'h1A:        br_cond = (rj_val <  rkd_val);
      6'h1B:        br_cond = (rj_val >= rkd_val);
      default:      br_cond = 1'b0;
    endcase
  end

  assign br_taken = ds_valid & ds_ready_go & es_allowin & ~flush & ~ds_adef & br_cond;
  assign br_zip   = {br_taken, br_taken ? br_target : XLEN'(0)};

  // A taken branch squashes the sequential bundle fetched alongside it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid <= 1'b0;
      ds_adef  <= 1'b0;
      ds_pc    <= '0;
      ds_inst  <= '0;
    end else if (flush) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs2ds_valid & ~br_taken;
      if (fs2ds_valid) {ds_adef, ds_pc, ds_inst} <= fs2ds_bus;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: one bypassing and one stall-only instance share stimulus;
// a transaction-level model predicts each cycle's outputs, a negedge monitor compares.
module tb_id_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         fs2ds_valid;
  logic [64:0]  fs2ds_bus;
  logic         es_allowin;
  logic [38:0]  es_fwd, ms_fwd;
  logic [37:0]  ws_fwd;
  logic         ws_ex, ertn_flush;

  logic         ds_allowin [2];
  logic [32:0]  br_zip     [2];
  logic         ds2es_valid[2];
  logic [128:0] ds2es_bus  [2];
  logic [4:0]   raddr1     [2];
  logic [4:0]   raddr2     [2];
  logic [31:0]  rdata1     [2];
  logic [31:0]  rdata2     [2];

  logic [31:0]  rf [32];

  always #5 clk = ~clk;

  assign rdata1[0] = rf[raddr1[0]];
  assign rdata2[0] = rf[raddr2[0]];
  assign rdata1[1] = rf[raddr1[1]];
  assign rdata2[1] = rf[raddr2[1]];

  id_stage #(.FWD_EN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .fs2ds_valid(fs2ds_valid), .fs2ds_bus(fs2ds_bus),
    .ds_allowin(ds_allowin[0]), .br_zip(br_zip[0]), .ds2es_valid(ds2es_valid[0]),
    .ds2es_bus(ds2es_bus[0]), .es_allowin(es_allowin), .rf_raddr1(raddr1[0]),
    .rf_raddr2(raddr2[0]), .rf_rdata1(rdata1[0]), .rf_rdata2(rdata2[0]),
    .es_fwd(es_fwd), .ms_fwd(ms_fwd), .ws_fwd(ws_fwd), .ws_ex(ws_ex), .ertn_flush(ertn_flush)
  );

  id_stage #(.FWD_EN(1'b0)) dut_nf (
    .clk(clk), .resetn(resetn), .fs2ds_valid(fs2ds_valid), .fs2ds_bus(fs2ds_bus),
    .ds_allowin(ds_allowin[1]), .br_zip(br_zip[1]), .ds2es_valid(ds2es_valid[1]),
    .ds2es_bus(ds2es_bus[1]), .es_allowin(es_allowin), .rf_raddr1(raddr1[1]),
    .rf_raddr2(raddr2[1]), .rf_rdata1(rdata1[1]), .rf_rdata2(rdata2[1]),
    .es_fwd(es_fwd), .ms_fwd(ms_fwd), .ws_fwd(ws_fwd), .ws_ex(ws_ex), .ertn_flush(ertn_flush)
  );

  typedef struct packed {
    logic         allowin;
    logic         valid;
    logic [32:0]  br;
    logic [128:0] bus;
    logic [4:0]   a1;
    logic [4:0]   a2;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model of the instruction held in decode, per instance (0 = bypass, 1 = stall-only)
  logic        m_v    [2];
  logic        m_adef [2];
  logic [31:0] m_pc   [2];
  logic [31:0] m_inst [2];

  function automatic logic [31:0] resolve(input logic [4:0] a, input bit fwd);
    if (a == 5'd0) return 32'd0;
    if (fwd) begin
      if (es_fwd[37] && es_fwd[36:32] == a) return es_fwd[31:0];
      if (ms_fwd[37] && ms_fwd[36:32] == a) return ms_fwd[31:0];
      if (ws_fwd[37] && ws_fwd[36:32] == a) return ws_fwd[31:0];
    end
    return rf[a];
  endfunction

  function automatic bit blocks(input logic [4:0] a, input bit fwd);
    bit e, m, w;
    if (a == 5'd0) return 1'b0;
    e = es_fwd[37] && es_fwd[36:32] == a;
    m = ms_fwd[37] && ms_fwd[36:32] == a;
    w = ws_fwd[37] && ws_fwd[36:32] == a;
    if (fwd) return (e && es_fwd[38]) || (m && ms_fwd[38]);
    return e || m || w;
  endfunction

  function automatic exp_t model_eval(input int k);
    exp_t        e;
    logic [31:0] inst, v1, v2, tgt;
    logic signed [31:0] o16, o26;
    logic [5:0]  op;
    logic [4:0]  a1, a2;
    bit          fwd, is_br, is_st, use1, stall, flush, cond, taken;
    inst  = m_inst[k];
    op    = inst[31:26];
    fwd   = (k == 0);
    is_br = (op >= 6'h16) && (op <= 6'h1B);
    is_st = (inst[31:22] >= 10'h0A4) && (inst[31:22] <= 10'h0A6);
    use1  = !(op == 6'h14 || op == 6'h15 || inst[31:25] == 7'h0A || inst[31:25] == 7'h0E);
    a1    = inst[9:5];
    a2    = (is_br || is_st) ? inst[4:0] : inst[14:10];
    stall = (use1 && blocks(a1, fwd)) || blocks(a2, fwd);
    v1    = resolve(a1, fwd);
    v2    = resolve(a2, fwd);
    flush = ws_ex || ertn_flush;
    o16   = {{16{inst[25]}}, inst[25:10]};
    o16   = o16 * 4;
    o26   = {{6{inst[9]}}, inst[9:0], inst[25:10]};
    o26   = o26 * 4;
    cond  = 1'b0;
    tgt   = m_pc[k] + o16;
    case (op)
      6'h13: begin cond = 1'b1; tgt = v1 + o16; end
      6'h14, 6'h15: begin cond = 1'b1; tgt = m_pc[k] + o26; end
      6'h16: cond = (v1 == v2);
      6'h17: cond = (v1 != v2);
      6'h18: cond = ($signed(v1) < $signed(v2));
      6'h19: cond = ($signed(v1) >= $signed(v2));
      6'h1A: cond = (v1 < v2);
      6'h1B: cond = (v1 >= v2);
      default: cond = 1'b0;
    endcase
    taken     = m_v[k] && !stall && es_allowin && !flush && !m_adef[k] && cond;
    e.allowin = !m_v[k] || (!stall && es_allowin);
    e.valid   = m_v[k] && !stall && !flush;
    e.br      = taken ? {1'b1, tgt} : 33'd0;
    e.bus     = {m_adef[k], m_pc[k], m_inst[k], v1, v2};
    e.a1      = a1;
    e.a2      = a2;
    return e;
  endfunction

  task automatic model_commit(input int k, input exp_t e);
    if (!resetn) begin
      m_v[k] = 1'b0; m_adef[k] = 1'b0; m_pc[k] = 32'd0; m_inst[k] = 32'd0;
    end else if (ws_ex || ertn_flush) begin
      m_v[k] = 1'b0;
    end else if (e.allowin) begin
      m_v[k] = fs2ds_valid && !e.br[32];
      if (fs2ds_valid) {m_adef[k], m_pc[k], m_inst[k]} = fs2ds_bus;
    end
  endtask

  // One cycle: predict, queue for the monitor, then advance the model past the edge
  task automatic apply();
    exp_t e0, e1;
    e0 = model_eval(0);
    e1 = model_eval(1);
    q.push_back(e0);
    q.push_back(e1);
    n_vec++;
    @(posedge clk);
    #1;
    model_commit(0, e0);
    model_commit(1, e1);
  endtask

  task automatic chk(input string nm, input int k, input logic [128:0] act, input logic [128:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() >= 2) begin
      for (int k = 0; k < 2; k++) begin
        exp_t e;
        e = q.pop_front();
        chk("allowin", k, 129'(ds_allowin[k]), 129'(e.allowin));
        chk("valid",   k, 129'(ds2es_valid[k]), 129'(e.valid));
        chk("br_zip",  k, 129'(br_zip[k]), 129'(e.br));
        chk("bus",     k, ds2es_bus[k], e.bus);
        chk("raddr1",  k, 129'(raddr1[k]), 129'(e.a1));
        chk("raddr2",  k, 129'(raddr2[k]), 129'(e.a2));
      end
    end
  end

  task automatic fetch(input logic adef, input logic [31:0] pc, input logic [31:0] inst);
    fs2ds_valid = 1'b1;
    fs2ds_bus   = {adef, pc, inst};
  endtask

  task automatic no_fetch();
    fs2ds_valid = 1'b0;
    fs2ds_bus   = {1'b0, $urandom, $urandom};
  endtask

  task automatic clear_fwd();
    es_fwd = '0; ms_fwd = '0; ws_fwd = '0; ws_ex = 1'b0; ertn_flush = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rj, rk, rd;
    logic [15:0] o;
    rj = 5'($urandom_range(0, 7));
    rk = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    o  = 16'($urandom);
    case ($urandom_range(0, 8))
      0: return {10'h00A, 12'($urandom), rj, rd};
      1: return {17'h00020, rk, rj, rd};
      2, 3: return {6'($urandom_range(22, 27)), o, rj, rd};
      4: return {6'($urandom_range(20, 21)), 26'($urandom)};
      5: return {6'h13, o, rj, rd};
      6: return {(($urandom_range(0, 1) == 1) ? 7'h0A : 7'h0E), 20'($urandom), rd};
      7: return {10'($urandom_range(164, 166)), 12'($urandom), rj, rd};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEADBEEF;
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 1'b0; m_adef[k] = 1'b0; m_pc[k] = 32'd0; m_inst[k] = 32'd0;
    end
    resetn = 1'b0;
    es_allowin = 1'b1;
    clear_fwd();
    no_fetch();
    @(posedge clk);
    #1;
    apply();
    apply();
    resetn = 1'b1;
    apply();

    // addi.w r1,r1,1 passes straight through
    rf[1] = 32'h0000_0041;
    fetch(1'b0, 32'h1C00_0000, 32'h0280_0421); apply();
    no_fetch(); apply();

    // beq r1,r2,+8 taken; the bundle fetched alongside is dropped
    rf[1] = 32'd5; rf[2] = 32'd5;
    fetch(1'b0, 32'h1C00_0010, 32'h5800_0822); apply();
    fetch(1'b0, 32'h1C00_0014, 32'h0280_0421); apply();
    no_fetch(); apply(); apply();

    // load-use on r3 from EX, then released via MEM bypass
    es_fwd = {1'b1, 1'b1, 5'd3, 32'h0};
    fetch(1'b0, 32'h1C00_0020, 32'h0010_1464); apply();
    no_fetch(); apply(); apply();
    es_fwd = '0; ms_fwd = {1'b0, 1'b1, 5'd3, 32'h0000_1234}; apply();
    ms_fwd = '0; apply();

    // bypass priority on r6: EX, then MEM, then WB
    es_fwd = {1'b0, 1'b1, 5'd6, 32'hA};
    ms_fwd = {1'b0, 1'b1, 5'd6, 32'hB};
    ws_fwd = {1'b1, 5'd6, 32'hC};
    es_allowin = 1'b0;
    fetch(1'b0, 32'h1C00_0030, 32'h0280_04C7); apply();
    no_fetch(); apply();
    es_fwd = '0; apply();
    ms_fwd = '0; apply();
    es_allowin = 1'b1; ws_fwd = '0; apply(); apply();

    // flush while stalled on load-use
    es_fwd = {1'b1, 1'b1, 5'd3, 32'h0};
    fetch(1'b0, 32'h1C00_0040, 32'h0010_1464); apply();
    no_fetch(); apply();
    ws_ex = 1'b1; apply();
    clear_fwd(); apply(); apply();

    // jirl r0,r1,0 with WB writing r1
    rf[1] = 32'h1C00_0100;
    ws_fwd = {1'b1, 5'd1, 32'h1C00_0200};
    fetch(1'b0, 32'h1C00_0050, 32'h4C00_0020); apply();
    no_fetch(); apply(); apply();
    ws_fwd = '0; apply(); apply();

    // adef bundles never branch
    rf[1] = 32'd5; rf[2] = 32'd5;
    fetch(1'b1, 32'h1C00_0060, 32'h5800_0822); apply();
    fetch(1'b1, 32'h1C00_0064, 32'h0340_0000); apply();
    no_fetch(); apply(); apply();

    // ertn flush with a bundle arriving
    fetch(1'b0, 32'h1C00_0070, 32'h0280_0421); apply();
    ertn_flush = 1'b1; fetch(1'b0, 32'h1C00_0074, 32'h0280_0421); apply();
    ertn_flush = 1'b0; no_fetch(); apply();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(1, 31)] = $urandom;
      fs2ds_valid = ($urandom_range(0, 9) < 7);
      fs2ds_bus   = {($urandom_range(0, 19) == 0), ($urandom & 32'hFFFF_FFFC), rand_inst()};
      es_allowin  = ($urandom_range(0, 4) != 0);
      es_fwd      = {($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                     5'($urandom_range(0, 7)), 32'($urandom)};
      ms_fwd      = {($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                     5'($urandom_range(0, 7)), 32'($urandom)};
      ws_fwd      = {($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), 32'($urandom)};
      ws_ex       = ($urandom_range(0, 29) == 0);
      ertn_flush  = ($urandom_range(0, 49) == 0);
      apply();
    end

    clear_fwd();
    no_fetch();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
